// File: rtl/masked_sbox_sequencer.sv
// masked_sbox_sequencer
//   Byte-serial front/back end for one masked GF(2^8) inverter instance.
//   A full masked state is buffered, fed one masked byte per cycle into the
//   inverter, and a byte index (never data) rides a tag pipe alongside so the
//   returning masked inverse lands in the right result slot. The finished state
//   is held on out_state until the downstream consumer takes it.
//
//   Build option: define MASKED_SBOX_SEQ_AFFINE_EN to apply the AES affine map
//   to each captured share (0x63 added to share 0 only), giving masked SubBytes.
//   Left undefined, the raw masked inverse is stored and the affine map is
//   expected downstream. Timing and handshake are the same in both builds.

module masked_sbox_sequencer #(
   parameter int NUM_SHARES = 2,
   parameter int LATENCY    = 4,
   parameter int NUM_BYTES  = 16
)(
   input  logic                              in_clock,
   input  logic                              in_reset,
   input  logic                              in_valid,
   output logic                              out_in_ready,
   input  logic [NUM_BYTES*NUM_SHARES*8-1:0] in_state,
   output logic [NUM_SHARES*8-1:0]           out_inv_a,
   input  logic [NUM_SHARES*8-1:0]           in_inv_b,
   output logic                              out_busy,
   output logic                              out_valid,
   input  logic                              in_ready,
   output logic [NUM_BYTES*NUM_SHARES*8-1:0] out_state
);

   localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   typedef logic [NUM_SHARES-1:0][7:0]                mbyte_t;
   typedef logic [NUM_BYTES-1:0][NUM_SHARES-1:0][7:0] mstate_t;
   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t                      fsm;
   logic [IDX_W-1:0]            feed_cnt;
   mstate_t                     in_buf;
   mstate_t                     res_buf;
   // Stage 0 shadows the out_inv_a register; stages 1..LATENCY shadow the
   // inverter, so stage LATENCY lines up with the byte on in_inv_b.
   logic [LATENCY:0]            vld_pipe;
   logic [LATENCY:0][IDX_W-1:0] idx_pipe;
   mbyte_t                      inv_b;
   mbyte_t                      cap_byte;
   logic                        accept;
   logic                        drain_done;

`ifdef MASKED_SBOX_SEQ_AFFINE_EN
   // Linear part of the AES affine map; it distributes over XOR, so it can be
   // applied to each share independently.
   function automatic logic [7:0] aes_lin(input logic [7:0] x);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]};
   endfunction
`endif

   assign inv_b     = mbyte_t'(in_inv_b);
   assign out_state = res_buf;

   // Per-share capture transform: each output share depends on its own inverter share only
   for (genvar s = 0; s < NUM_SHARES; s++) begin : g_share
`ifdef MASKED_SBOX_SEQ_AFFINE_EN
      if (s == 0) begin : g_const
         assign cap_byte[s] = aes_lin(inv_b[s]) ^ 8'h63;
      end else begin : g_lin
         assign cap_byte[s] = aes_lin(inv_b[s]);
      end
`else
      assign cap_byte[s] = inv_b[s];
`endif
   end

   // Accept in IDLE, or in DONE while the result is being taken (no bubble)
   assign out_in_ready = (fsm == IDLE) | ((fsm == DONE) & in_ready);
   assign accept       = out_in_ready & in_valid;

   // Only the tail stage may still be live once the last capture is due
   assign drain_done   = ~|vld_pipe[LATENCY-1:0];

   // Control FSM with registered inverter feed, busy and valid outputs
   always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
         fsm       <= IDLE;
         feed_cnt  <= '0;
         in_buf    <= '0;
         out_inv_a <= '0;
         out_valid <= 1'b0;
         out_busy  <= 1'b0;
      end else begin
         out_inv_a <= '0;
         case (fsm)
            IDLE: begin
               if (accept) begin
                  in_buf   <= mstate_t'(in_state);
                  feed_cnt <= '0;
                  fsm      <= FEED;
               end
            end
            FEED: begin
               out_inv_a <= in_buf[feed_cnt];
               if (feed_cnt == LAST_IDX) begin
                  feed_cnt <= '0;
                  fsm      <= DRAIN;
               end else begin
                  feed_cnt <= feed_cnt + IDX_W'(1);
               end
            end
            DRAIN: begin
               if (drain_done) begin
                  fsm       <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (in_ready) begin
                  out_valid <= 1'b0;
                  if (accept) begin
                     in_buf   <= mstate_t'(in_state);
                     feed_cnt <= '0;
                     fsm      <= FEED;
                  end else begin
                     fsm <= IDLE;
                  end
               end
            end
            default: fsm <= IDLE;
         endcase
         // Busy while the inverter holds a live byte: first fed byte through last returned byte
         out_busy <= (fsm == FEED) | ((fsm == DRAIN) & ~drain_done);
      end
   end

   // Tag pipe: valid bit and byte index of each byte travelling through the inverter
   always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
         vld_pipe <= '0;
         idx_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[LATENCY-1:0], (fsm == FEED)};
         idx_pipe <= {idx_pipe[LATENCY-1:0], feed_cnt};
      end
   end

   // Result capture: the byte on in_inv_b is written to the slot named by the pipe tail
   always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
         res_buf <= '0;
      end else if (vld_pipe[LATENCY]) begin
         res_buf[idx_pipe[LATENCY]] <= cap_byte;
      end
   end

endmodule

// File: tb/tb_masked_sbox_sequencer.sv
// Bench for masked_sbox_sequencer. A behavioural masked inverter (unmask, field
// inverse by search, fresh random remask every cycle, LAT-cycle delay) closes the
// loop; expected results come from GF(2^8) arithmetic and the AES affine rule.
// Follows MASKED_SBOX_SEQ_AFFINE_EN the same way the design does.

module tb_masked_sbox_sequencer;
   localparam int NS  = 2;
   localparam int LAT = 4;
   localparam int NB  = 16;
   localparam int W   = NB*NS*8;

   typedef logic [NB-1:0][NS-1:0][7:0] st_t;
   typedef logic [NB-1:0][7:0]         pl_t;
   typedef logic [NS-1:0][7:0]         mb_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready = 1'b0;
   logic [W-1:0]  in_state = '0;
   logic          out_in_ready, out_busy, out_valid;
   logic [NS*8-1:0] out_inv_a, in_inv_b;
   logic [W-1:0]  out_state;
   int            n_chk = 0;
   int            n_pass = 0;
   mb_t           inv_pipe [LAT];

   always #5 clk = ~clk;

   masked_sbox_sequencer #(.NUM_SHARES(NS), .LATENCY(LAT), .NUM_BYTES(NB)) dut (
      .in_clock(clk), .in_reset(rst_n), .in_valid(in_valid), .out_in_ready(out_in_ready),
      .in_state(in_state), .out_inv_a(out_inv_a), .in_inv_b(in_inv_b), .out_busy(out_busy),
      .out_valid(out_valid), .in_ready(in_ready), .out_state(out_state));

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] r;
      r = 8'h00;
      for (int y = 1; y < 256; y++)
         if (gmul(x, 8'(y)) == 8'h01) r = 8'(y);
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] y, c, b;
      y = ginv(x);
      c = 8'h63;
      for (int i = 0; i < 8; i++)
         b[i] = y[i] ^ y[(i+4)%8] ^ y[(i+5)%8] ^ y[(i+6)%8] ^ y[(i+7)%8] ^ c[i];
      return b;
   endfunction

   function automatic logic [7:0] exp_byte(input logic [7:0] x);
`ifdef MASKED_SBOX_SEQ_AFFINE_EN
      return sbox(x);
`else
      return ginv(x);
`endif
   endfunction

   function automatic logic [7:0] unmask(input mb_t m);
      logic [7:0] v;
      v = 8'h00;
      for (int s = 0; s < NS; s++) v ^= m[s];
      return v;
   endfunction

   function automatic mb_t remask(input logic [7:0] v);
      mb_t m;
      logic [7:0] acc;
      acc = v;
      for (int s = 1; s < NS; s++) begin
         m[s] = 8'($urandom_range(0, 255));
         acc ^= m[s];
      end
      m[0] = acc;
      return m;
   endfunction

   function automatic st_t mask_state(input pl_t pl, input bit zero_mask);
      st_t st;
      logic [7:0] acc;
      for (int i = 0; i < NB; i++) begin
         acc = pl[i];
         for (int s = 1; s < NS; s++) begin
            st[i][s] = zero_mask ? 8'h00 : 8'($urandom_range(0, 255));
            acc ^= st[i][s];
         end
         st[i][0] = acc;
      end
      return st;
   endfunction

   function automatic pl_t rand_pl();
      pl_t p;
      for (int i = 0; i < NB; i++) p[i] = 8'($urandom_range(0, 255));
      return p;
   endfunction

   function automatic int count_bad(input st_t res, input pl_t pl);
      int e;
      e = 0;
      for (int i = 0; i < NB; i++)
         if (unmask(res[i]) !== exp_byte(pl[i])) e++;
      return e;
   endfunction

   // Behavioural masked inverter sharing clock and reset with the sequencer
   assign in_inv_b = inv_pipe[LAT-1];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < LAT; j++) inv_pipe[j] <= '0;
      end else begin
         inv_pipe[0] <= remask(ginv(unmask(mb_t'(out_inv_a))));
         for (int j = 1; j < LAT; j++) inv_pipe[j] <= inv_pipe[j-1];
      end
   end

   // Drives one state in and follows it to out_valid; caller sits 1 time unit after an edge
   task automatic do_op(input pl_t pl, input bit zero_mask, input bit rel_prev, input bit noise,
                        output st_t res, output int lat, output int busy_n,
                        output int feed_err, output logic acc_rdy);
      st_t st;
      st = mask_state(pl, zero_mask);
      in_state = st;
      in_valid = 1'b1;
      in_ready = rel_prev;
      #1 acc_rdy = out_in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_ready = 1'b0;
      lat = -1; busy_n = 0; feed_err = 0;
      for (int n = 0; n < 200; n++) begin
         busy_n += int'(out_busy);
         if (n >= 1 && n <= NB && mb_t'(out_inv_a) !== st[n-1]) feed_err++;
         if (out_valid) begin
            lat = n;
            break;
         end
         if (noise && n >= 1) begin
            in_valid = 1'b1;
            in_state = mask_state(rand_pl(), 1'b0);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      res = st_t'(out_state);
   endtask

   task automatic release_done();
      in_ready = 1'b1;
      @(posedge clk); #1;
      in_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_state = mask_state(rand_pl(), 1'b0);
      @(posedge clk); #1;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
      n_chk++; if (out_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", out_busy); else n_pass++;
      n_chk++; if (out_inv_a !== '0) $display("FAIL rst_inv_a: got %h want 0", out_inv_a); else n_pass++;
      n_chk++; if (out_state !== '0) $display("FAIL rst_state: got %h want 0", out_state); else n_pass++;
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      n_chk++; if (out_in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", out_in_ready); else n_pass++;
   endtask

   task automatic test_plain();
      pl_t pl; st_t res; int lat, bn, fe; logic ar;
      for (int i = 0; i < NB; i++) pl[i] = 8'(i);
      do_op(pl, 1'b1, 1'b0, 1'b0, res, lat, bn, fe, ar);
      n_chk++; if (ar !== 1'b1) $display("FAIL plain_accept: got %b want 1", ar); else n_pass++;
      n_chk++; if (lat != NB+LAT+1) $display("FAIL plain_latency: got %0d want %0d", lat, NB+LAT+1); else n_pass++;
      n_chk++; if (fe != 0) $display("FAIL plain_feed: %0d bytes misplaced, want 0", fe); else n_pass++;
      n_chk++; if (bn != NB+LAT) $display("FAIL plain_busy: got %0d want %0d", bn, NB+LAT); else n_pass++;
`ifdef MASKED_SBOX_SEQ_AFFINE_EN
      n_chk++; if (unmask(res[0]) !== 8'h63) $display("FAIL plain_b0: got %h want 63", unmask(res[0])); else n_pass++;
      n_chk++; if (unmask(res[1]) !== 8'h7c) $display("FAIL plain_b1: got %h want 7c", unmask(res[1])); else n_pass++;
`else
      n_chk++; if (unmask(res[0]) !== 8'h00) $display("FAIL plain_b0: got %h want 00", unmask(res[0])); else n_pass++;
      n_chk++; if (unmask(res[1]) !== 8'h01) $display("FAIL plain_b1: got %h want 01", unmask(res[1])); else n_pass++;
`endif
      n_chk++; if (count_bad(res, pl) != 0) $display("FAIL plain_result: %0d bytes wrong, want 0", count_bad(res, pl)); else n_pass++;
      in_ready = 1'b1; #1;
      n_chk++; if (out_in_ready !== 1'b1) $display("FAIL plain_done_ready: got %b want 1", out_in_ready); else n_pass++;
      @(posedge clk); #1; in_ready = 1'b0;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL plain_release: out_valid %b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_stall();
      pl_t pl; st_t res; int lat, bn, fe; logic ar;
      int e_vld, e_st, e_rdy;
      logic [127:0] fips;
      fips = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
      for (int i = 0; i < NB; i++) pl[i] = fips[127-8*i -: 8];
      do_op(pl, 1'b0, 1'b0, 1'b0, res, lat, bn, fe, ar);
      e_vld = 0; e_st = 0; e_rdy = 0;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_state = mask_state(rand_pl(), 1'b0);
         #1;
         if (out_valid !== 1'b1) e_vld++;
         if (out_state !== W'(res)) e_st++;
         if (out_in_ready !== 1'b0) e_rdy++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_chk++; if (e_vld != 0) $display("FAIL stall_valid: dropped %0d cycles, want 0", e_vld); else n_pass++;
      n_chk++; if (e_st != 0) $display("FAIL stall_stable: changed %0d cycles, want 0", e_st); else n_pass++;
      n_chk++; if (e_rdy != 0) $display("FAIL stall_in_ready: high %0d cycles, want 0", e_rdy); else n_pass++;
      n_chk++; if (count_bad(st_t'(out_state), pl) != 0) $display("FAIL stall_result: %0d bytes wrong, want 0", count_bad(st_t'(out_state), pl)); else n_pass++;
`ifdef MASKED_SBOX_SEQ_AFFINE_EN
      n_chk++; if (unmask(res[0]) !== 8'hd4) $display("FAIL stall_fips_b0: got %h want d4", unmask(res[0])); else n_pass++;
`endif
      release_done();
   endtask

   task automatic test_back_to_back();
      pl_t pa, pb; st_t ra, rb; int lat, bn, fe; logic ar;
      pa = rand_pl(); pb = rand_pl();
      do_op(pa, 1'b0, 1'b0, 1'b0, ra, lat, bn, fe, ar);
      n_chk++; if (count_bad(ra, pa) != 0) $display("FAIL b2b_first: %0d bytes wrong, want 0", count_bad(ra, pa)); else n_pass++;
      do_op(pb, 1'b0, 1'b1, 1'b0, rb, lat, bn, fe, ar);
      n_chk++; if (ar !== 1'b1) $display("FAIL b2b_accept: got %b want 1", ar); else n_pass++;
      n_chk++; if (fe != 0) $display("FAIL b2b_feed: %0d bytes misplaced, want 0", fe); else n_pass++;
      n_chk++; if (lat != NB+LAT+1) $display("FAIL b2b_latency: got %0d want %0d", lat, NB+LAT+1); else n_pass++;
      n_chk++; if (count_bad(rb, pb) != 0) $display("FAIL b2b_second: %0d bytes wrong, want 0", count_bad(rb, pb)); else n_pass++;
      release_done();
   endtask

   task automatic test_reset_mid();
      pl_t pl, pc; st_t st, rc; int lat, bn, fe; logic ar;
      pl = rand_pl();
      st = mask_state(pl, 1'b0);
      in_state = st; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      n_chk++; if (mb_t'(out_inv_a) !== st[7]) $display("FAIL mid_byte7: got %h want %h", out_inv_a, st[7]); else n_pass++;
      rst_n = 1'b0; #1;
      n_chk++; if (out_busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", out_busy); else n_pass++;
      n_chk++; if (out_inv_a !== '0) $display("FAIL mid_inv_a: got %h want 0", out_inv_a); else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1; #1;
      n_chk++; if (out_in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", out_in_ready); else n_pass++;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", out_valid); else n_pass++;
      n_chk++; if (out_state !== '0) $display("FAIL mid_stale: got %h want 0", out_state); else n_pass++;
      pc = rand_pl();
      do_op(pc, 1'b0, 1'b0, 1'b0, rc, lat, bn, fe, ar);
      n_chk++; if (lat != NB+LAT+1) $display("FAIL mid_next_latency: got %0d want %0d", lat, NB+LAT+1); else n_pass++;
      n_chk++; if (count_bad(rc, pc) != 0) $display("FAIL mid_next_result: %0d bytes wrong, want 0", count_bad(rc, pc)); else n_pass++;
      release_done();
   endtask

   task automatic test_ignore_valid();
      pl_t pl; st_t res; int lat, bn, fe; logic ar;
      pl = rand_pl();
      do_op(pl, 1'b0, 1'b0, 1'b1, res, lat, bn, fe, ar);
      n_chk++; if (lat != NB+LAT+1) $display("FAIL ignore_latency: got %0d want %0d", lat, NB+LAT+1); else n_pass++;
      n_chk++; if (fe != 0) $display("FAIL ignore_feed: %0d bytes misplaced, want 0", fe); else n_pass++;
      n_chk++; if (count_bad(res, pl) != 0) $display("FAIL ignore_result: %0d bytes wrong, want 0", count_bad(res, pl)); else n_pass++;
      release_done();
   endtask

   task automatic test_busy();
      pl_t pl; st_t res; int lat, bn, fe; logic ar;
      for (int r = 0; r < 4; r++) begin
         pl = rand_pl();
         do_op(pl, 1'b0, 1'b0, 1'b0, res, lat, bn, fe, ar);
         n_chk++; if (bn != NB+LAT) $display("FAIL busy_count[%0d]: got %0d want %0d", r, bn, NB+LAT); else n_pass++;
         n_chk++; if (count_bad(res, pl) != 0) $display("FAIL busy_result[%0d]: %0d bytes wrong, want 0", r, count_bad(res, pl)); else n_pass++;
         release_done();
         n_chk++; if (out_busy !== 1'b0) $display("FAIL busy_idle[%0d]: got %b want 0", r, out_busy); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_plain();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_ignore_valid();
      test_busy();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
